// File: rtl/mem_cache_ctrl_wb.sv
// MEM-stage cache controller with a posted write buffer.
// Read misses wait for the buffer to drain before the SRAM line fill.
module mem_cache_ctrl_wb #(
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 32,
    parameter int          LINE_WORDS  = 2,
    parameter int          CACHE_IDX_W = 17,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int          WB_DEPTH    = 4,
    localparam int         LINE_W      = DATA_W * LINE_WORDS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_r_en,
    input  logic                   mem_w_en,
    input  logic [ADDR_W-1:0]      address,
    input  logic [DATA_W-1:0]      write_data,
    output logic                   ready,
    output logic [DATA_W-1:0]      read_data,
    input  logic                   cache_hit,
    input  logic [DATA_W-1:0]      cache_rd_data,
    output logic                   cache_re,
    output logic                   cache_we,
    output logic                   cache_inv,
    output logic [CACHE_IDX_W-1:0] cache_addr,
    output logic [LINE_W-1:0]      cache_wr_data,
    input  logic                   sram_ready,
    input  logic [LINE_W-1:0]      sram_rd_data,
    output logic                   sram_re,
    output logic                   sram_we,
    output logic [ADDR_W-1:0]      sram_addr,
    output logic [DATA_W-1:0]      sram_wr_data,
    output logic                   wb_empty
);

    localparam int WS_W  = $clog2(LINE_WORDS);
    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        MISS_WAIT,
        MISS_READ
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0]      gen;
    logic [CACHE_IDX_W-1:0] idx;
    logic [WS_W-1:0]        ws;

    assign gen = {address[ADDR_W-1:2], 2'b00} - ADDR_W'(BASE_ADDR);
    assign idx = gen[CACHE_IDX_W+1:2];
    assign ws  = idx[WS_W-1:0];

    logic [ADDR_W-1:0] wb_addr_q [WB_DEPTH];
    logic [DATA_W-1:0] wb_data_q [WB_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wb_empty_q;
    logic              full;
    logic              push;
    logic              drain;
    logic              pop;

    assign full  = (cnt_q == CNT_W'(WB_DEPTH));
    assign push  = (state_q == IDLE) && !mem_r_en && mem_w_en && !full;
    assign drain = !wb_empty_q && (state_q != MISS_READ);
    assign pop   = drain && sram_ready;

    assign wb_empty = wb_empty_q;
    assign sram_we  = drain;

    // Buffer pointer and occupancy next-state
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Buffer control registers; reset discards queued stores
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            wb_empty_q <= 1'b1;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            wb_empty_q <= (cnt_d == '0);
        end
    end

    // Buffer storage written at the tail on an accepted store
    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr_q[tail_q] <= address;
            wb_data_q[tail_q] <= write_data;
        end
    end

    // Main FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and request-side outputs
    always_comb begin
        state_d       = state_q;
        ready         = 1'b0;
        read_data     = '0;
        cache_re      = 1'b0;
        cache_we      = 1'b0;
        cache_inv     = 1'b0;
        cache_wr_data = '0;
        sram_re       = 1'b0;
        sram_addr     = '0;
        sram_wr_data  = '0;
        if (drain) begin
            sram_addr    = wb_addr_q[head_q];
            sram_wr_data = wb_data_q[head_q];
        end
        unique case (state_q)
            IDLE: begin
                if (mem_r_en) begin
                    cache_re = 1'b1;
                    if (cache_hit) begin
                        ready     = 1'b1;
                        read_data = cache_rd_data;
                    end else if (wb_empty_q) begin
                        sram_re   = 1'b1;
                        sram_addr = address;
                        state_d   = MISS_READ;
                    end else begin
                        state_d = MISS_WAIT;
                    end
                end else if (mem_w_en) begin
                    if (!full) begin
                        ready     = 1'b1;
                        cache_inv = 1'b1;
                    end
                end else begin
                    ready = 1'b1;
                end
            end
            MISS_WAIT: begin
                if (wb_empty_q) begin
                    sram_re   = 1'b1;
                    sram_addr = address;
                    state_d   = MISS_READ;
                end
            end
            MISS_READ: begin
                sram_re   = 1'b1;
                sram_addr = address;
                if (sram_ready) begin
                    cache_we      = 1'b1;
                    cache_wr_data = sram_rd_data;
                    read_data     = sram_rd_data[DATA_W*int'(ws) +: DATA_W];
                    ready         = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cache_addr = (cache_re || cache_we || cache_inv) ? idx : '0;

endmodule

// File: tb/tb_mem_cache_ctrl_wb.sv
// Scoreboard bench for mem_cache_ctrl_wb.
// Directed stimulus; a negedge monitor retires reads and SRAM writes.
module tb_mem_cache_ctrl_wb;

    logic        clk;
    logic        rst;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        ready;
    logic [31:0] read_data;
    logic        cache_hit;
    logic [31:0] cache_rd_data;
    logic        cache_re;
    logic        cache_we;
    logic        cache_inv;
    logic [16:0] cache_addr;
    logic [63:0] cache_wr_data;
    logic        sram_ready;
    logic [63:0] sram_rd_data;
    logic        sram_re;
    logic        sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wr_data;
    logic        wb_empty;

    mem_cache_ctrl_wb dut (
        .clk          (clk),
        .rst          (rst),
        .mem_r_en     (mem_r_en),
        .mem_w_en     (mem_w_en),
        .address      (address),
        .write_data   (write_data),
        .ready        (ready),
        .read_data    (read_data),
        .cache_hit    (cache_hit),
        .cache_rd_data(cache_rd_data),
        .cache_re     (cache_re),
        .cache_we     (cache_we),
        .cache_inv    (cache_inv),
        .cache_addr   (cache_addr),
        .cache_wr_data(cache_wr_data),
        .sram_ready   (sram_ready),
        .sram_rd_data (sram_rd_data),
        .sram_re      (sram_re),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wr_data (sram_wr_data),
        .wb_empty     (wb_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        fill;
    } rd_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_exp_t;

    rd_exp_t rdq[$];
    wr_exp_t wrq[$];
    rd_exp_t rd_m;
    wr_exp_t wr_m;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Monitor: retire completed reads and SRAM write handshakes
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_r_en && ready) begin
                if (rdq.size() == 0) begin
                    chk("rd_unexpected", 64'(rdq.size()), 64'd1);
                end else begin
                    rd_m = rdq.pop_front();
                    chk("rd_data", 64'(read_data), 64'(rd_m.data));
                    chk("rd_fill", 64'(cache_we), 64'(rd_m.fill));
                end
            end else begin
                chk("cache_we_idle", 64'(cache_we), 64'd0);
            end
            if (sram_we && sram_ready) begin
                if (wrq.size() == 0) begin
                    chk("wr_unexpected", 64'(wrq.size()), 64'd1);
                end else begin
                    wr_m = wrq.pop_front();
                    chk("wr_addr", 64'(sram_addr), 64'(wr_m.addr));
                    chk("wr_data", 64'(sram_wr_data), 64'(wr_m.data));
                end
            end
            chk("re_we_overlap", 64'(sram_re & sram_we), 64'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drain_all();
        int n;
        n = 0;
        sram_ready = 1'b1;
        smp();
        while (!wb_empty && n < 20) begin
            nxt();
            smp();
            n++;
        end
        chk("drain_empty", 64'(wb_empty), 64'd1);
        nxt();
        sram_ready = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        mem_r_en      = 1'b0;
        mem_w_en      = 1'b0;
        address       = '0;
        write_data    = '0;
        cache_hit     = 1'b0;
        cache_rd_data = '0;
        sram_ready    = 1'b0;
        sram_rd_data  = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        smp();
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_wb_empty", 64'(wb_empty), 64'd1);
        chk("rst_sram_re", 64'(sram_re), 64'd0);
        chk("rst_sram_we", 64'(sram_we), 64'd0);
        chk("rst_cache_re", 64'(cache_re), 64'd0);
        chk("rst_cache_we", 64'(cache_we), 64'd0);
        chk("rst_cache_inv", 64'(cache_inv), 64'd0);
        chk("rst_read_data", 64'(read_data), 64'd0);
        chk("rst_sram_addr", 64'(sram_addr), 64'd0);
        chk("rst_cache_addr", 64'(cache_addr), 64'd0);
        chk("rst_cache_wr", cache_wr_data, 64'd0);
        nxt();
        rst = 1'b0;

        // read hit
        mem_r_en      = 1'b1;
        address       = 32'h408;
        cache_hit     = 1'b1;
        cache_rd_data = 32'hDEADBEEF;
        rdq.push_back('{32'hDEADBEEF, 1'b0});
        smp();
        chk("hit_ready", 64'(ready), 64'd1);
        chk("hit_cache_addr", 64'(cache_addr), 64'd2);
        chk("hit_sram_re", 64'(sram_re), 64'd0);
        chk("hit_cache_re", 64'(cache_re), 64'd1);
        nxt();
        mem_r_en      = 1'b0;
        cache_hit     = 1'b0;
        cache_rd_data = '0;

        // read miss, empty buffer, sram_ready three cycles later
        mem_r_en = 1'b1;
        address  = 32'h40C;
        rdq.push_back('{32'h11111111, 1'b1});
        for (int i = 0; i < 4; i++) begin
            sram_ready   = (i == 3);
            sram_rd_data = (i == 3) ? 64'h11111111_22222222 : 64'd0;
            smp();
            chk("miss_sram_re", 64'(sram_re), 64'd1);
            chk("miss_ready", 64'(ready), 64'(i == 3));
            chk("miss_sram_addr", 64'(sram_addr), 64'h40C);
            if (i == 3) begin
                chk("miss_fill_line", cache_wr_data, 64'h11111111_22222222);
                chk("miss_fill_idx", 64'(cache_addr), 64'd3);
            end
            nxt();
        end
        mem_r_en     = 1'b0;
        sram_ready   = 1'b0;
        sram_rd_data = '0;
        smp();
        chk("miss_done_re", 64'(sram_re), 64'd0);
        chk("miss_done_ready", 64'(ready), 64'd1);
        nxt();

        // store burst into a full buffer, SRAM stalled
        for (int i = 0; i < 5; i++) begin
            mem_w_en   = 1'b1;
            address    = 32'h500 + 32'(4 * i);
            write_data = 32'hA0000000 + 32'(i);
            smp();
            chk("st_ready", 64'(ready), 64'(i < 4));
            chk("st_inv", 64'(cache_inv), 64'(i < 4));
            if (i < 4) begin
                wrq.push_back('{address, write_data});
                nxt();
            end
        end
        chk("full_head_we", 64'(sram_we), 64'd1);
        chk("full_head_addr", 64'(sram_addr), 64'h500);
        nxt();
        sram_ready = 1'b1;
        smp();
        chk("full_pop_refuse", 64'(ready), 64'd0);
        chk("full_pop_inv", 64'(cache_inv), 64'd0);
        nxt();
        sram_ready = 1'b0;
        smp();
        chk("after_pop_ready", 64'(ready), 64'd1);
        chk("after_pop_inv", 64'(cache_inv), 64'd1);
        wrq.push_back('{address, write_data});
        nxt();
        mem_w_en   = 1'b0;
        address    = '0;
        write_data = '0;
        drain_all();
        chk("burst_sb_empty", 64'(wrq.size()), 64'd0);

        // read miss behind two buffered stores
        for (int i = 0; i < 2; i++) begin
            mem_w_en   = 1'b1;
            address    = 32'h600 + 32'(4 * i);
            write_data = 32'hB0 + 32'(i);
            smp();
            chk("wst_ready", 64'(ready), 64'd1);
            wrq.push_back('{address, write_data});
            nxt();
        end
        mem_w_en = 1'b0;
        mem_r_en = 1'b1;
        address  = 32'h410;
        rdq.push_back('{32'h44444444, 1'b1});
        smp();
        chk("mw0_sram_re", 64'(sram_re), 64'd0);
        chk("mw0_sram_we", 64'(sram_we), 64'd1);
        chk("mw0_ready", 64'(ready), 64'd0);
        nxt();
        sram_ready = 1'b1;
        smp();
        chk("mw1_sram_re", 64'(sram_re), 64'd0);
        chk("mw1_sram_we", 64'(sram_we), 64'd1);
        nxt();
        smp();
        chk("mw2_sram_re", 64'(sram_re), 64'd0);
        chk("mw2_wb_empty", 64'(wb_empty), 64'd0);
        nxt();
        sram_ready = 1'b0;
        smp();
        chk("mw3_sram_re", 64'(sram_re), 64'd1);
        chk("mw3_wb_empty", 64'(wb_empty), 64'd1);
        chk("mw3_sram_we", 64'(sram_we), 64'd0);
        chk("mw3_ready", 64'(ready), 64'd0);
        chk("mw3_addr", 64'(sram_addr), 64'h410);
        nxt();
        sram_ready   = 1'b1;
        sram_rd_data = 64'h33333333_44444444;
        smp();
        chk("mw4_ready", 64'(ready), 64'd1);
        nxt();
        mem_r_en     = 1'b0;
        sram_ready   = 1'b0;
        sram_rd_data = '0;
        chk("mw_sb_empty", 64'(wrq.size()), 64'd0);

        // simultaneous read and write with a hit
        mem_r_en      = 1'b1;
        mem_w_en      = 1'b1;
        cache_hit     = 1'b1;
        address       = 32'h414;
        write_data    = 32'h12345678;
        cache_rd_data = 32'hCAFEF00D;
        rdq.push_back('{32'hCAFEF00D, 1'b0});
        smp();
        chk("sim_ready", 64'(ready), 64'd1);
        chk("sim_inv", 64'(cache_inv), 64'd0);
        nxt();
        mem_r_en      = 1'b0;
        mem_w_en      = 1'b0;
        cache_hit     = 1'b0;
        cache_rd_data = '0;
        smp();
        chk("sim_no_push", 64'(wb_empty), 64'd1);
        chk("sim_no_we", 64'(sram_we), 64'd0);
        nxt();

        // reset during MISS_READ
        mem_r_en = 1'b1;
        address  = 32'h418;
        smp();
        chk("rmr_sram_re", 64'(sram_re), 64'd1);
        nxt();
        #1;
        rst      = 1'b1;
        mem_r_en = 1'b0;
        #1;
        chk("rmr_rst_re", 64'(sram_re), 64'd0);
        nxt();
        rst          = 1'b0;
        sram_ready   = 1'b1;
        sram_rd_data = 64'h55555555_66666666;
        smp();
        chk("rmr_stale_we", 64'(cache_we), 64'd0);
        chk("rmr_stale_ready", 64'(ready), 64'd1);
        nxt();
        sram_ready   = 1'b0;
        sram_rd_data = '0;

        // reset with three stores buffered and a miss waiting
        for (int i = 0; i < 3; i++) begin
            mem_w_en   = 1'b1;
            address    = 32'h700 + 32'(4 * i);
            write_data = 32'hC0 + 32'(i);
            smp();
            chk("rst_st_ready", 64'(ready), 64'd1);
            nxt();
        end
        mem_w_en = 1'b0;
        mem_r_en = 1'b1;
        address  = 32'h41C;
        smp();
        chk("rmw_sram_re", 64'(sram_re), 64'd0);
        nxt();
        smp();
        chk("rmw_sram_we", 64'(sram_we), 64'd1);
        #2;
        rst      = 1'b1;
        mem_r_en = 1'b0;
        #1;
        chk("rmw_rst_re", 64'(sram_re), 64'd0);
        chk("rmw_rst_we", 64'(sram_we), 64'd0);
        chk("rmw_rst_empty", 64'(wb_empty), 64'd1);
        nxt();
        rst          = 1'b0;
        sram_ready   = 1'b1;
        sram_rd_data = 64'h77777777_88888888;
        smp();
        chk("rmw_stale_we", 64'(cache_we), 64'd0);
        chk("rmw_post_we", 64'(sram_we), 64'd0);
        chk("rmw_post_empty", 64'(wb_empty), 64'd1);
        nxt();
        sram_ready   = 1'b0;
        sram_rd_data = '0;
        smp();

        chk("final_rdq", 64'(rdq.size()), 64'd0);
        chk("final_wrq", 64'(wrq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
